// File: rtl/index_agu_pkg.sv
// -----------------------------------------------------------------------------
// agu_pkg
// Shared constants and the FSM state type for the indexed address generator.
//   ADDR_W      : width of the 6502 address bus
//   BYTE_W      : width of one add pass through the byte-wide CLA
//   agu_state_t : IDLE (wait for start), LO (low-byte add), HI (carry fix-up)
// -----------------------------------------------------------------------------
package agu_pkg;

    localparam int ADDR_W = 16;
    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LO   = 2'b01,
        HI   = 2'b10
    } agu_state_t;

endpackage

// File: rtl/index_agu_if.sv
// -----------------------------------------------------------------------------
// index_agu_if
// Request/result bundle between the instruction sequencer and the AGU.
//   start/base/index/force_fix/zp_mode : request, driven by the sequencer
//   busy                               : AGU cannot accept a request
//   dummy_valid                        : addr holds the unfixed (dummy-read) address
//   addr_valid                         : addr holds the final address
//   addr                               : registered address result
//   page_cross                         : carry out of the low-byte add
// Modports: master = sequencer side, slave = AGU side.
// -----------------------------------------------------------------------------
interface index_agu_if;
    import agu_pkg::*;

    logic                start;
    logic [ADDR_W-1:0]   base;
    logic [BYTE_W-1:0]   index;
    logic                force_fix;
    logic                zp_mode;
    logic                busy;
    logic                dummy_valid;
    logic                addr_valid;
    logic [ADDR_W-1:0]   addr;
    logic                page_cross;

    modport master (
        output start, base, index, force_fix, zp_mode,
        input  busy, dummy_valid, addr_valid, addr, page_cross
    );

    modport slave (
        input  start, base, index, force_fix, zp_mode,
        output busy, dummy_valid, addr_valid, addr, page_cross
    );

endinterface

// File: rtl/index_agu_cla.sv
// -----------------------------------------------------------------------------
// CLA_8bit
// 8-bit carry-lookahead adder. Each carry is formed directly from the
// generate/propagate terms of the lower bits and cin, so there is no
// bit-to-bit carry dependency in the netlist description.
//   a, b : operands
//   cin  : carry in
//   sum  : a + b + cin (mod 256)
//   cout : carry out of bit 7
// -----------------------------------------------------------------------------
module CLA_8bit (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // c[k+1] = g[k] | p[k]g[k-1] | ... | p[k..0]cin, expanded per bit
    always_comb begin
        logic cy;
        c    = '0;
        c[0] = cin;
        for (int k = 0; k < 8; k++) begin
            cy = cin;
            for (int j = 0; j <= k; j++) begin
                cy = g[j] | (p[j] & cy);
            end
            c[k+1] = cy;
        end
    end

    assign sum  = p ^ c[7:0];
    assign cout = c[8];

endmodule

// File: rtl/index_agu.sv
// -----------------------------------------------------------------------------
// index_agu
// Indexed address generator for the 6502 core. Forms base + index one byte at
// a time through one shared CLA_8bit: low byte first, then (only on a page
// crossing or a forced fix-up) the carry into the high byte. The unfixed
// address is presented with dummy_valid so the bus can issue the dummy read.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : index_agu_if.slave (request in, address/status out)
// Parameter ZP_PAGE: high byte placed on the address in zero-page mode.
// -----------------------------------------------------------------------------
module index_agu
    import agu_pkg::*;
#(
    parameter logic [BYTE_W-1:0] ZP_PAGE = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    index_agu_if.slave  bus
);

    agu_state_t          state, state_nxt;

    logic [ADDR_W-1:0]   base_q;
    logic [BYTE_W-1:0]   index_q;
    logic                ff_q;
    logic                zp_q;
    logic                carry_q;

    logic [ADDR_W-1:0]   addr_q;
    logic                pc_q;
    logic                dv_q, dv_nxt;
    logic                av_q, av_nxt;

    logic [BYTE_W-1:0]   cla_a, cla_b, cla_sum;
    logic                cla_cin, cla_cout;

    // Operand mux: the HI pass reuses the adder to ripple the saved carry
    // into the base high byte. Any other state presents the low-byte add.
    always_comb begin
        cla_a   = base_q[BYTE_W-1:0];
        cla_b   = index_q;
        cla_cin = 1'b0;
        if (state == HI) begin
            cla_a   = base_q[ADDR_W-1:BYTE_W];
            cla_b   = '0;
            cla_cin = carry_q;
        end
    end

    CLA_8bit u_cla (
        .a    (cla_a),
        .b    (cla_b),
        .cin  (cla_cin),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // Next-state and output pulses
    always_comb begin
        state_nxt = IDLE;
        dv_nxt    = 1'b0;
        av_nxt    = 1'b0;
        case (state)
            IDLE: state_nxt = bus.start ? LO : IDLE;
            LO: begin
                // zp mode never fixes up: the wrap stays inside the page
                if (zp_q || (!cla_cout && !ff_q)) begin
                    av_nxt = 1'b1;
                end else begin
                    dv_nxt    = 1'b1;
                    state_nxt = HI;
                end
            end
            HI:      av_nxt    = 1'b1;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q  <= '0;
            index_q <= '0;
            ff_q    <= 1'b0;
            zp_q    <= 1'b0;
            carry_q <= 1'b0;
            addr_q  <= '0;
            pc_q    <= 1'b0;
            dv_q    <= 1'b0;
            av_q    <= 1'b0;
        end else begin
            dv_q <= dv_nxt;
            av_q <= av_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        base_q  <= bus.base;
                        index_q <= bus.index;
                        ff_q    <= bus.force_fix;
                        zp_q    <= bus.zp_mode;
                        pc_q    <= 1'b0;
                    end
                end
                LO: begin
                    carry_q <= cla_cout;
                    pc_q    <= cla_cout & ~zp_q;
                    addr_q  <= zp_q ? {ZP_PAGE, cla_sum}
                                    : {base_q[ADDR_W-1:BYTE_W], cla_sum};
                end
                HI:      addr_q[ADDR_W-1:BYTE_W] <= cla_sum;
                default: ;
            endcase
        end
    end

    // busy follows the state register, so it is already low in the
    // addr_valid cycle and a back-to-back start is accepted there.
    assign bus.busy        = (state != IDLE);
    assign bus.dummy_valid = dv_q;
    assign bus.addr_valid  = av_q;
    assign bus.addr        = addr_q;
    assign bus.page_cross  = pc_q;

endmodule

// File: tb/tb_index_agu.sv
// -----------------------------------------------------------------------------
// tb_index_agu
// Self-checking bench for index_agu: directed cases plus randomized requests
// compared against an arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_index_agu;
    import agu_pkg::*;

    localparam logic [7:0] ZP = 8'h00;

    logic clk = 1'b0;
    logic rst;

    index_agu_if bus ();

    index_agu #(.ZP_PAGE(ZP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    logic [15:0] last_addr = 16'h0000;
    logic        last_pc   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic scramble();
        bus.start     = 1'b1;
        bus.base      = 16'($urandom);
        bus.index     = 8'($urandom);
        bus.force_fix = 1'($urandom);
        bus.zp_mode   = 1'($urandom);
    endtask

    // Issue one request from a cycle where busy=0 and check every cycle up to
    // and including the addr_valid cycle. Returns positioned in that cycle.
    task automatic run_op(input logic [15:0] b, input logic [7:0] i,
                          input logic ff, input logic zp, input logic hold);
        int          lo;
        logic        pc, fix;
        logic [15:0] dmy, fin;
        lo  = int'(b[7:0]) + int'(i);
        pc  = !zp && (lo > 255);
        fix = !zp && (pc || ff);
        dmy = {b[15:8], 8'(lo)};
        fin = zp ? {ZP, 8'(lo)} : 16'(int'(b) + int'(i));

        bus.start = 1'b1; bus.base = b; bus.index = i;
        bus.force_fix = ff; bus.zp_mode = zp;
        @(posedge clk); #1;
        if (hold) scramble(); else bus.start = 1'b0;
        chk("lo_busy", bus.busy, 1);
        chk("lo_dv", bus.dummy_valid, 0);
        chk("lo_av", bus.addr_valid, 0);
        chk("lo_pc_clr", bus.page_cross, 0);

        @(posedge clk); #1;
        if (fix) begin
            if (hold) scramble();
            chk("dmy_dv", bus.dummy_valid, 1);
            chk("dmy_av", bus.addr_valid, 0);
            chk("dmy_addr", bus.addr, dmy);
            chk("dmy_pc", bus.page_cross, pc);
            chk("dmy_busy", bus.busy, 1);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        chk("fin_av", bus.addr_valid, 1);
        chk("fin_dv", bus.dummy_valid, 0);
        chk("fin_addr", bus.addr, fin);
        chk("fin_pc", bus.page_cross, pc);
        chk("fin_busy", bus.busy, 0);
        last_addr = fin;
        last_pc   = pc;
    endtask

    task automatic idle(input int n);
        bus.start = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
            chk("idle_addr", bus.addr, last_addr);
            chk("idle_pc", bus.page_cross, last_pc);
            chk("idle_av", bus.addr_valid, 0);
            chk("idle_dv", bus.dummy_valid, 0);
            chk("idle_busy", bus.busy, 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0; bus.base = '0; bus.index = '0;
        bus.force_fix = 1'b0; bus.zp_mode = 1'b0;
        #12;
        chk("rst_addr", bus.addr, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_dv", bus.dummy_valid, 0);
        chk("rst_av", bus.addr_valid, 0);
        chk("rst_pc", bus.page_cross, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed cases
        run_op(16'h1234, 8'h10, 1'b0, 1'b0, 1'b0); idle(1);
        run_op(16'h12F0, 8'h20, 1'b0, 1'b0, 1'b0); idle(2);
        run_op(16'h1234, 8'h10, 1'b1, 1'b0, 1'b0); idle(1);
        run_op(16'h12FF, 8'h02, 1'b1, 1'b1, 1'b0); idle(1);
        run_op(16'hFFFF, 8'h01, 1'b0, 1'b0, 1'b0);
        // Back-to-back: start in the addr_valid cycle
        run_op(16'h2000, 8'h05, 1'b0, 1'b0, 1'b0);
        // start held through busy with changing operands
        run_op(16'h12F0, 8'h20, 1'b0, 1'b0, 1'b1);
        run_op(16'h4321, 8'h01, 1'b0, 1'b0, 1'b1);
        idle(2);

        // Reset pulsed during HI
        bus.start = 1'b1; bus.base = 16'h12F0; bus.index = 8'h20;
        bus.force_fix = 1'b0; bus.zp_mode = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        chk("hi_dv", bus.dummy_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_addr", bus.addr, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_dv", bus.dummy_valid, 0);
        chk("mid_rst_av", bus.addr_valid, 0);
        chk("mid_rst_pc", bus.page_cross, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        last_addr = 16'h0000;
        last_pc   = 1'b0;
        idle(3);

        // Randomized requests
        for (int n = 0; n < 200; n++) begin
            run_op(16'($urandom), 8'($urandom),
                   ($urandom_range(3) == 0), ($urandom_range(3) == 0),
                   ($urandom_range(7) == 0));
            if ($urandom_range(1) == 0) idle(int'($urandom_range(2)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
